// File: rtl/dm_resp_pkg.sv
// Shared types and helpers for the data-memory responder.
package dm_resp_pkg;

    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    // Responder sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_EXEC = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    // Replace the bytes of old_word whose enable bit is set with the
    // matching bytes of new_word; disabled lanes keep their old contents.
    function automatic logic [DATA_W-1:0] be_merge(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [BE_W-1:0]   be
    );
        logic [DATA_W-1:0] merged;
        merged = old_word;
        for (int i = 0; i < BE_W; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                merged[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/dm_array.sv
// Single-port synchronous word array with per-byte write enables.
// Contents are intentionally not reset so data survives a responder reset.
module dm_array
    import dm_resp_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = 10
) (
    input  logic              clock,
    input  logic              en,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    input  logic [BE_W-1:0]   be,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [DEPTH_WORDS];
    logic [DATA_W-1:0] rdata_r;

    // One access per enabled cycle: byte-merged write or registered read.
    always_ff @(posedge clock) begin
        if (en) begin
            if (we) begin
                mem_r[idx] <= be_merge(mem_r[idx], wdata, be);
            end else begin
                rdata_r <= mem_r[idx];
            end
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/dm_resp.sv
// Data-memory responder: accepts one load/store at a time, inserts a fixed
// number of wait states, performs the access, then holds the response until
// the requester takes it.
module dm_resp
    import dm_resp_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err
);

    localparam int          IDX_W       = $clog2(DEPTH_WORDS);
    localparam logic        HAS_WAIT_C  = (WAIT_CYCLES > 0);
    localparam logic [3:0]  WAIT_LOAD_C = 4'(WAIT_CYCLES - 1);
    // End of the mapped region, one bit wider so a region at the top of the
    // address space does not wrap to zero.
    localparam logic [32:0] END_ADDR_C  = {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) << 2);

    state_e            state_r;
    state_e            state_next_s;
    logic [3:0]        wait_cnt_r;
    logic              cap_we_r;
    logic [31:0]       cap_addr_r;
    logic [DATA_W-1:0] cap_wdata_r;
    logic [BE_W-1:0]   cap_be_r;
    logic              exec_err_r;
    logic              exec_load_r;
    logic              req_ready_r;
    logic              resp_valid_r;
    logic [DATA_W-1:0] resp_rdata_r;
    logic              resp_err_r;

    logic              err_s;
    logic [IDX_W-1:0]  idx_s;
    logic              arr_en_s;
    logic [DATA_W-1:0] arr_rdata_s;

    // Decode the captured request: alignment, range and word index.
    always_comb begin
        err_s    = (cap_addr_r[1:0] != 2'b00)
                || ({1'b0, cap_addr_r} < {1'b0, BASE_ADDR})
                || ({1'b0, cap_addr_r} >= END_ADDR_C);
        idx_s    = IDX_W'((cap_addr_r - BASE_ADDR) >> 2);
        arr_en_s = (state_r == ST_EXEC) && !err_s;
    end

    // Next-state selection.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    state_next_s = HAS_WAIT_C ? ST_WAIT : ST_EXEC;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_r == 4'd0) begin
                    state_next_s = ST_EXEC;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_EXEC: begin
                state_next_s = ST_RESP;
            end
            ST_RESP: begin
                if (resp_valid_r && resp_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RESP;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register and registered request-ready derived from the next state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            req_ready_r <= 1'b1;
        end else begin
            state_r     <= state_next_s;
            req_ready_r <= (state_next_s == ST_IDLE);
        end
    end

    // Wait-state counter: loaded on acceptance, counts down while waiting.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt_r <= 4'd0;
        end else if ((state_r == ST_IDLE) && req_valid) begin
            wait_cnt_r <= WAIT_LOAD_C;
        end else if ((state_r == ST_WAIT) && (wait_cnt_r != 4'd0)) begin
            wait_cnt_r <= wait_cnt_r - 4'd1;
        end
    end

    // Capture the request on acceptance; inputs are ignored in other states.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cap_we_r    <= 1'b0;
            cap_addr_r  <= 32'd0;
            cap_wdata_r <= 32'd0;
            cap_be_r    <= 4'd0;
        end else if ((state_r == ST_IDLE) && req_valid) begin
            cap_we_r    <= req_we;
            cap_addr_r  <= req_addr;
            cap_wdata_r <= req_wdata;
            cap_be_r    <= req_be;
        end
    end

    // Remember the execute-cycle decode for use once the array read lands.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            exec_err_r  <= 1'b0;
            exec_load_r <= 1'b0;
        end else if (state_r == ST_EXEC) begin
            exec_err_r  <= err_s;
            exec_load_r <= !cap_we_r && !err_s;
        end
    end

    // Response registers: load on the first response cycle, hold until taken.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            resp_valid_r <= 1'b0;
            resp_rdata_r <= 32'd0;
            resp_err_r   <= 1'b0;
        end else if ((state_r == ST_RESP) && !resp_valid_r) begin
            resp_valid_r <= 1'b1;
            resp_rdata_r <= exec_load_r ? arr_rdata_s : 32'd0;
            resp_err_r   <= exec_err_r;
        end else if ((state_r == ST_RESP) && resp_ready) begin
            resp_valid_r <= 1'b0;
            resp_rdata_r <= 32'd0;
            resp_err_r   <= 1'b0;
        end
    end

    dm_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clock (clock),
        .en    (arr_en_s),
        .we    (cap_we_r),
        .idx   (idx_s),
        .wdata (cap_wdata_r),
        .be    (cap_be_r),
        .rdata (arr_rdata_s)
    );

    assign req_ready  = req_ready_r;
    assign resp_valid = resp_valid_r;
    assign resp_rdata = resp_rdata_r;
    assign resp_err   = resp_err_r;

endmodule

// File: doc/dm_resp.md
Name: dm_resp

Overview:
- Data-memory responder: the memory end of the load/store interface that the single-cycle CPU core drives for lw/sw.
- Accepts one word-wide request at a time over a valid/ready handshake.
- Applies a programmable number of wait states, then returns read data or a write acknowledgement over a second valid/ready handshake.
- Holds its own word-addressed storage array.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the array (power of two, >=2)
- WAIT_CYCLES, 2, wait states between request acceptance and response presentation (0..15)
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be DEPTH_WORDS*4 aligned

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request this cycle
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data
- req_be  in  4  byte enables; bit i covers bits [8i+7:8i]
- resp_valid  out  1  response present
- resp_ready  in  1  requester accepts response
- resp_rdata  out  32  load data (0 for stores and errors)
- resp_err  out  1  misaligned or out-of-range access

Behaviour:
- Reset: async assert forces state IDLE; clears the wait counter and the captured request. While reset is high and after release: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
- Storage array is not reset; its contents survive reset.
- States:
  - IDLE: req_ready=1. On req_valid=1, capture we/addr/wdata/be. Go to WAIT if WAIT_CYCLES>0, else to EXEC.
  - WAIT: req_ready=0. Counter loads WAIT_CYCLES-1 on entry and decrements each cycle. Go to EXEC when the counter is 0.
  - EXEC: one cycle. Decode the captured request:
    - err = (addr[1:0]!=0) or (addr<BASE_ADDR) or (addr>=BASE_ADDR+4*DEPTH_WORDS).
    - Store with no error: write the bytes with be=1 at index (addr-BASE_ADDR)>>2.
    - Load with no error: register array data into resp_rdata.
    - Go to RESP.
  - RESP: resp_valid=1; resp_rdata and resp_err are stable. When resp_ready=1, go to IDLE with resp_valid=0 next cycle.
- Timing: request accepted at edge N gives resp_valid high after edge N+WAIT_CYCLES+2.
- Back-to-back requests: the next request can be accepted in the cycle after the response handshake.
- req_ready is a registered function of state only, never combinational on req_valid.
- Loads ignore req_be and return the full word.
- Store with be=4'b0000 still completes with no array change and err=0.
- Errors:
  - An errored store never modifies the array.
  - An errored load returns rdata=0.
- resp_rdata for a store is 0.
- Reset mid-operation: an asserted reset in WAIT or RESP abandons the request. A store only commits in EXEC, so a store reset before EXEC leaves the array unchanged.
- Request inputs are ignored outside IDLE; no queueing.
- Width rules:
  - Index width is clog2(DEPTH_WORDS).
  - Counter width is 4.
  - Address comparison is unsigned, 32-bit.
  - BASE_ADDR+4*DEPTH_WORDS is computed in 33 bits so a top-of-space region does not wrap.

Decomposition:
- Shared package holds:
  - state encoding enum (IDLE, WAIT, EXEC, RESP)
  - DATA_W=32 and BE_W=4 constants
  - function for byte-masked merge of old and new word
- One natural sub-module: dm_array, a single-port synchronous word array with byte write-enables.
- The FSM, counter and error decode stay in dm_resp.

Test Plan:
- Reset then store/load with BASE_ADDR=0, WAIT_CYCLES=2: store addr 0x10, wdata 0xDEADBEEF, be=4'hF, then load 0x10 -> load returns rdata=0xDEADBEEF, err=0. Each resp_valid rises exactly 4 edges after its acceptance edge.
- Byte enables: store 0x11223344 to 0x20 with be=F, then store 0xAABBCCDD with be=4'b0101, then load 0x20 -> rdata=0x11BB33DD.
- Errors:
  - Load 0x22 (misaligned) -> err=1, rdata=0.
  - Store 0x1000 with DEPTH_WORDS=1024 -> err=1; a following load of 0x0 returns its prior value unchanged.
- Backpressure: hold resp_ready=0 for 5 cycles after resp_valid -> resp_valid, rdata and err stay constant and req_ready stays 0. Raise resp_ready -> req_ready=1 in the next cycle.
- Reset mid-store: accept a store of 0xCAFEF00D to 0x40 (prior value 0x0), assert reset during WAIT -> outputs return to reset values immediately; a later load of 0x40 returns 0x0.
- WAIT_CYCLES=0 build: accept at edge N -> resp_valid high after edge N+2. Back-to-back loads to 0x0 and 0x4 complete with no lost or duplicated responses.
